// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial packed-BCD adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_pkg;

    localparam int        BCD_W    = 4;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// Single-digit decimal correcting adder.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a_d, b_d : one BCD digit of each operand
//   c        : decimal carry-in for this digit
//   digit    : corrected BCD result digit
//   k        : decimal carry-out of this digit
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c,
    output logic [3:0] digit,
    output logic       k
);

    logic [4:0] z;

    always_comb begin
        z = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c};
        // Decimal overflow: binary carry, or the 4-bit sum is 10..15
        // (bit 3 set together with bit 2 or bit 1).
        k = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
        // Adding 6 skips the six unused codes; bit 4 is the carry already in k.
        digit = k ? (z[3:0] + BCD_CORR) : z[3:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one decimal digit per clock, LSD first.
// Latency: DIGITS cycles from operand accept to out_valid; issue interval DIGITS+2.
// Backpressure: result held in DONE while out_ready=0; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : high while digits are being computed
//   err                 : sticky out-of-range digit flag, only when the
//                         BCD_DIGIT_CHECK_EN macro is defined
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
`ifdef BCD_DIGIT_CHECK_EN
    output logic                  err,
`endif
    output logic                  busy
);

    localparam int W  = BCD_W * DIGITS;
    localparam int CW = $clog2(DIGITS) + 1;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    sum_r;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic [3:0]      digit;
    logic            k;
    logic            accept;
    logic            last;

    assign accept = in_valid && (state == IDLE);
    assign last   = (cnt == CW'(DIGITS - 1));

    bcd_digit_add u_digit_add (
        .a_d   (a_sh[3:0]),
        .b_d   (b_sh[3:0]),
        .c     (carry),
        .digit (digit),
        .k     (k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            sum_r <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> BCD_W;
            b_sh  <= b_sh >> BCD_W;
            // New digit enters at the top; after DIGITS shifts digit 0 is at [3:0].
            sum_r <= (sum_r >> BCD_W) | (W'(digit) << (W - BCD_W));
            carry <= k;
            cnt   <= cnt + CW'(1);
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (state == RUN && (a_sh[3:0] > 4'd9 || b_sh[3:0] > 4'd9)) begin
            err <= 1'b1;
        end
    end
`endif

    // The carry flop holds the top digit's decimal carry once DONE is reached.
    assign sum       = sum_r;
    assign cout      = carry;
    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4) against a decimal model.
// Latency: checks result appears exactly DIGITS cycles after accept.
// Backpressure: exercises out_ready hold, ignored in_valid, mid-operation reset.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MOD    = 10 ** DIGITS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef BCD_DIGIT_CHECK_EN
    logic         err;
`endif

    int checks   = 0;
    int failures = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef BCD_DIGIT_CHECK_EN
        .err       (err),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference model: packed BCD <-> integer, plain addition.
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Drives one operation; returns observations for the caller to check.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input bit ack,
                          output logic [W-1:0] rs, output logic rc,
                          output int lat, output logic busy_seen,
                          output logic rdy_after);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom);
        busy_seen = busy;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rs = sum;
        rc = cout;
        rdy_after = 1'b0;
        if (ack) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            rdy_after = in_ready && !out_valid;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (sum !== '0 || cout !== 1'b0) begin failures++; $display("FAIL reset_sum got=%h/%b want=0/0", sum, cout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic         vc [5];
        logic [W-1:0] es [5];
        logic         ec [5];
        logic [W-1:0] rs;
        logic         rc, bz, rdy;
        int           lat;
        va = '{16'h1234, 16'h9999, 16'h0000, 16'h5000, 16'h0999};
        vb = '{16'h5678, 16'h0001, 16'h0000, 16'h5000, 16'h0000};
        vc = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
        es = '{16'h6912, 16'h0000, 16'h0001, 16'h0000, 16'h1000};
        ec = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b1, rs, rc, lat, bz, rdy);
            checks++; if (rs !== es[i] || rc !== ec[i]) begin failures++; $display("FAIL vec%0d_sum got=%h/%b want=%h/%b", i, rs, rc, es[i], ec[i]); end
            checks++; if (lat != DIGITS) begin failures++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, DIGITS); end
            checks++; if (bz !== 1'b1) begin failures++; $display("FAIL vec%0d_busy got=%b want=1", i, bz); end
            checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL vec%0d_idle_after_ack got=%b want=1", i, rdy); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] xa, xb, rs, es;
        logic         xc, rc, ec, bz, rdy;
        int           lat, total;
        for (int i = 0; i < 30; i++) begin
            xa = rand_bcd();
            xb = rand_bcd();
            xc = 1'($urandom_range(0, 1));
            total = bcd2int(xa) + bcd2int(xb) + int'(xc);
            es = int2bcd(total % MOD);
            ec = (total >= MOD);
            run_op(xa, xb, xc, 1'b1, rs, rc, lat, bz, rdy);
            checks++; if (rs !== es || rc !== ec || lat != DIGITS) begin failures++; $display("FAIL rand%0d %h+%h+%b got=%h/%b lat=%0d want=%h/%b lat=%0d", i, xa, xb, xc, rs, rc, lat, es, ec, DIGITS); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] rs;
        logic         rc, bz, rdy;
        int           lat;
        run_op(16'h4821, 16'h3579, 1'b1, 1'b0, rs, rc, lat, bz, rdy);
        checks++; if (rs !== 16'h8401 || rc !== 1'b0) begin failures++; $display("FAIL bp_result got=%h/%b want=8401/0", rs, rc); end
        for (int i = 0; i < 6; i++) begin
            a = rand_bcd(); b = rand_bcd(); cin = 1'b1;
            in_valid = 1'(i % 2);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || sum !== 16'h8401 || cout !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d ov=%b ir=%b busy=%b sum=%h cout=%b want 1/0/0/8401/0", i, out_valid, in_ready, busy, sum, cout);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release ir=%b ov=%b want 1/0", in_ready, out_valid); end
        // Held-off in_valid pulses must not have started another operation.
        repeat (DIGITS + 2) @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_no_capture ov=%b busy=%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] rs;
        logic         rc, bz, rdy;
        int           lat;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== '0) begin
            failures++; $display("FAIL midrun_reset ov=%b ir=%b busy=%b sum=%h want 0/1/0/0000", out_valid, in_ready, busy, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIGITS + 3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrun_discard ov=%b want 0", out_valid); end
        run_op(16'h0005, 16'h0005, 1'b0, 1'b1, rs, rc, lat, bz, rdy);
        checks++; if (rs !== 16'h0010 || rc !== 1'b0 || lat != DIGITS) begin failures++; $display("FAIL after_reset got=%h/%b lat=%0d want=0010/0 lat=%0d", rs, rc, lat, DIGITS); end
    endtask

`ifdef BCD_DIGIT_CHECK_EN
    task automatic test_err();
        logic [W-1:0] rs;
        logic         rc, bz, rdy;
        int           lat;
        run_op(16'h000A, 16'h0000, 1'b0, 1'b0, rs, rc, lat, bz, rdy);
        checks++; if (err !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL err_set got=%b ov=%b want 1/1", err, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, lat, bz, rdy);
        checks++; if (err !== 1'b0 || rs !== 16'h0002) begin failures++; $display("FAIL err_clear err=%b sum=%h want 0/0002", err, rs); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid_run();
`ifdef BCD_DIGIT_CHECK_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial packed-BCD adder. Adds two DIGITS-wide packed BCD operands one decimal digit per clock, least-significant digit first, through a single-digit correcting adder. The decimal-carry term in that adder is the three-input OR of the 4-bit add carry-out with the two >9 detect products. The block consumes operand pairs from an upstream valid/ready source and presents the BCD sum and decimal carry-out to a downstream valid/ready sink.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; one clock, reset asserts asynchronously
- in_valid  input  1  operand pair and cin valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  4*DIGITS  packed BCD operand A, digit 0 in bits [3:0]
- b  input  4*DIGITS  packed BCD operand B
- cin  input  1  decimal carry-in
- out_valid  output  1  sum/cout valid
- out_ready  input  1  sink accepts result
- sum  output  4*DIGITS  packed BCD sum
- cout  output  1  decimal carry-out of the top digit
- busy  output  1  high in RUN
- err  output  1  invalid (>9) input digit seen; present only with BCD_DIGIT_CHECK_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a, b, cin into shift registers; clear digit counter and sum register; go to RUN.
- RUN: each cycle, the per-digit adder takes the current low digits of A and B plus the carry register:
  - z = a_d + b_d + c, 5 bits.
  - k = z[4] | (z[3]&z[2]) | (z[3]&z[1]).
  - digit = k ? (z+6)[3:0] : z[3:0].
  - carry register <= k.
  - Digit shifts into sum from the top (right-shift); A and B shift right by 4.
  - Counter increments; after digit DIGITS-1 go to DONE.
- DONE: out_valid=1, sum/cout stable. On out_ready, go to IDLE. Hold indefinitely while out_ready=0.
- in_valid outside IDLE is ignored, and the operands are not captured.
- Counter width: $clog2(DIGITS)+1. No wrap: exit on count==DIGITS-1.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, err=0, carry/counter/shift registers=0.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded and never presented.

## Timing
- Acceptance edge T0.
- Digits computed on edges T0+1 … T0+DIGITS.
- out_valid high from T0+DIGITS. Latency is DIGITS cycles from accept to result.
- Result handshake edge Tr → IDLE; in_ready high after Tr.
- Minimum issue interval is DIGITS+2 cycles. There is no overlap of result hold with the next accept.
- All outputs are registered. in_ready, out_valid and busy decode from state flops only.

## Configuration
- BCD_DIGIT_CHECK_EN defined:
  - During RUN, any a_d>9 or b_d>9 sets a sticky err flag.
  - err is cleared on accept and on reset, and is valid with out_valid.
  - The sum is still computed by the same correction rule.
- Undefined: the err port and the check logic are absent. Out-of-range digits produce the same sum with no flag.

## Structure
- Shared package bcd_pkg holds:
  - BCD_W=4
  - BCD_CORR=4'd6
  - the state enum type (IDLE/RUN/DONE)
- One sub-module, bcd_digit_add: combinational single-digit correcting adder (a_d, b_d, c → digit, k). Its k term is the three-input OR described above. The top holds the FSM, shift registers, counter and carry flop.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0 → sum=0x6912, cout=0, out_valid exactly 4 cycles after accept.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples through all digits).
- a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0; then a=0x5000, b=0x5000 → sum=0x0000, cout=1.
- Backpressure: out_ready=0 for 6 cycles after out_valid → sum/cout/out_valid stable, in_valid pulses ignored, in_ready=0; out_ready=1 → IDLE next cycle.
- Reset: assert rst_n=0 after 2 RUN digits → out_valid=0, sum=0, in_ready=1 immediately; a fresh 0x0005+0x0005 then gives 0x0010.
- BCD_DIGIT_CHECK_EN: a=0x000A, b=0x0000 → err=1 with out_valid. A following 0x0001+0x0001 → err=0, sum=0x0002.
